// File: rtl/hamming_serial_tx.sv
// Serial Hamming(7,4) transmitter: accepts a nibble on valid/ready, encodes it and shifts the
// codeword out LSB first, one bit per strobe_out pulse. Define HAMMING_PARITY_EN for SECDED framing.
module hamming_serial_tx #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       bit_out,
  output logic       strobe_out,
  output logic [7:0] code_word,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

`ifdef HAMMING_PARITY_EN
  localparam logic [2:0] LAST_BIT = 3'd7;
`else
  localparam logic [2:0] LAST_BIT = 3'd6;
`endif

  // Terminal gap count; GAP is never entered when GAP_CYCLES is 0.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] code_word_q, code_word_d;
  logic       last_bit_q, last_bit_d;
  logic       frame_done_q, frame_done_d;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] cw;
    cw    = '0;
    cw[2] = d[0];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[3] = d[1] ^ d[2] ^ d[3];
`ifdef HAMMING_PARITY_EN
    cw[7] = ^cw[6:0];
`endif
    return cw;
  endfunction

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block infers a latch.
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    gap_cnt_d    = gap_cnt_q;
    code_word_d  = code_word_q;
    last_bit_d   = last_bit_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_word_d = encode(in_data);
          bit_idx_d   = 3'd0;
          gap_cnt_d   = 4'd0;
          state_d     = SEND;
        end
      end
      SEND: begin
        last_bit_d = code_word_q[bit_idx_q];
        if (bit_idx_q == LAST_BIT) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else if (GAP_CYCLES == 0) begin
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          state_d   = GAP;
          gap_cnt_d = 4'd0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = SEND;
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      gap_cnt_q    <= '0;
      code_word_q  <= '0;
      last_bit_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      code_word_q  <= code_word_d;
      last_bit_q   <= last_bit_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs decode from state so an asynchronous reset clears them immediately.
  assign in_ready   = (state_q == IDLE);
  assign strobe_out = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign bit_out    = strobe_out ? code_word_q[bit_idx_q] : last_bit_q;
  assign code_word  = code_word_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Self-checking bench for hamming_serial_tx: one instance with GAP_CYCLES=1, one with GAP_CYCLES=0,
// checked against a positional Hamming model and a syndrome decoder kept in the bench.
module tb_hamming_serial_tx;

`ifdef HAMMING_PARITY_EN
  localparam int NBITS = 8;
`else
  localparam int NBITS = 7;
`endif
  localparam int P1     = 2;                    // strobe period of the GAP_CYCLES=1 instance
  localparam int LAST1  = 1 + (NBITS - 1) * P1; // cycle offset of the last strobe
  localparam int DONE1  = LAST1 + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, a_bit, a_strobe, a_busy, a_done;
  logic       b_ready, b_bit, b_strobe, b_busy, b_done;
  logic [7:0] a_cw, b_cw;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hamming_serial_tx #(.GAP_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .bit_out(a_bit), .strobe_out(a_strobe), .code_word(a_cw), .busy(a_busy), .frame_done(a_done)
  );

  hamming_serial_tx #(.GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .bit_out(b_bit), .strobe_out(b_strobe), .code_word(b_cw), .busy(b_busy), .frame_done(b_done)
  );

  // Codeword index i is Hamming position i+1; parity at position p covers positions with bit p set.
  function automatic logic [7:0] model_cw(input logic [3:0] d);
    logic [7:0] cw;
    int dpos [4];
    cw = '0;
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
    for (int k = 0; k < 4; k++) cw[dpos[k] - 1] = d[k];
    for (int p = 1; p <= 4; p = p * 2)
      for (int q = 1; q <= 7; q++)
        if (((q & p) != 0) && (q != p)) cw[p - 1] = cw[p - 1] ^ cw[q - 1];
`ifdef HAMMING_PARITY_EN
    cw[7] = ^cw[6:0];
`endif
    return cw;
  endfunction

  function automatic logic [3:0] model_decode(input logic [7:0] r);
    int syn;
    syn = 0;
    for (int q = 1; q <= 7; q++) if (r[q - 1]) syn = syn ^ q;
    if (syn != 0) r[syn - 1] = ~r[syn - 1];
    return {r[6], r[5], r[4], r[2]};
  endfunction

  // Sends one nibble through the GAP_CYCLES=1 instance and checks every cycle of the frame.
  // A nonzero pulse_at raises in_valid with 4'hF for one cycle at that offset mid-frame.
  task automatic frame_g1(input logic [3:0] nib, input int pulse_at, output logic [7:0] rx);
    logic [7:0] exp;
    logic exp_strobe;
    exp = model_cw(nib);
    rx  = '0;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL frame_ready_before nib=%h got %b want 1", nib, a_ready);
    end
    a_valid = 1'b1;
    a_data  = nib;
    @(posedge clk);
    for (int c = 1; c <= DONE1; c++) begin
      @(negedge clk);
      exp_strobe = (c <= LAST1) && (((c - 1) % P1) == 0);
      n_checks += 4;
      if (a_strobe !== exp_strobe) begin
        n_fail++; $display("FAIL frame_strobe nib=%h c=%0d got %b want %b", nib, c, a_strobe, exp_strobe);
      end
      if (a_busy !== (c <= LAST1)) begin
        n_fail++; $display("FAIL frame_busy nib=%h c=%0d got %b want %b", nib, c, a_busy, c <= LAST1);
      end
      if (a_done !== (c == DONE1)) begin
        n_fail++; $display("FAIL frame_done nib=%h c=%0d got %b want %b", nib, c, a_done, c == DONE1);
      end
      if (a_ready !== (c == DONE1)) begin
        n_fail++; $display("FAIL frame_in_ready nib=%h c=%0d got %b want %b", nib, c, a_ready, c == DONE1);
      end
      if (c <= LAST1) begin
        n_checks++;
        if (a_bit !== exp[(c - 1) / P1]) begin
          n_fail++; $display("FAIL frame_bit nib=%h c=%0d got %b want %b", nib, c, a_bit, exp[(c - 1) / P1]);
        end
        if (a_strobe === 1'b1) rx[(c - 1) / P1] = a_bit;
      end
      if (c == 1 || c == DONE1) begin
        n_checks++;
        if (a_cw !== exp) begin
          n_fail++; $display("FAIL frame_code_word nib=%h c=%0d got %h want %h", nib, c, a_cw, exp);
        end
      end
      if (c == 1) begin
        a_valid = 1'b0;
        a_data  = 4'($urandom_range(0, 15));
      end
      if (pulse_at > 0 && c == pulse_at) begin
        a_valid = 1'b1;
        a_data  = 4'hF;
      end
      if (pulse_at > 0 && c == pulse_at + 1) a_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b/%b want 1/1", a_ready, b_ready);
    end
    if (a_strobe !== 1'b0 || a_bit !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs strobe/bit/busy got %b%b%b want 000", a_strobe, a_bit, a_busy);
    end
    if (a_cw !== 8'h00 || b_cw !== 8'h00) begin
      n_fail++; $display("FAIL reset_code_word got %h/%h want 00/00", a_cw, b_cw);
    end
    if (a_done !== 1'b0 || b_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_done got %b/%b want 0/0", a_done, b_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b1 || a_strobe !== 1'b0 || a_cw !== 8'h00 || a_done !== 1'b0 || b_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_state cyc=%0d got ready=%b strobe=%b cw=%h done=%b want 1 0 00 0",
                 i, a_ready, a_strobe, a_cw, a_done);
      end
    end
  endtask

  task automatic test_known_frame();
    logic [7:0] rx;
    frame_g1(4'b1011, 0, rx);
    n_checks++;
`ifdef HAMMING_PARITY_EN
    if (rx !== 8'b0101_0101) begin
      n_fail++; $display("FAIL known_1011_bits got %b want 01010101", rx);
    end
`else
    if (rx[6:0] !== 7'b1010101) begin
      n_fail++; $display("FAIL known_1011_bits got %b want 1010101", rx[6:0]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1, e2;
    e1 = model_cw(4'b0001);
    e2 = model_cw(4'b1111);
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = 4'b0001;
    @(posedge clk);
    for (int c = 1; c <= 2 * NBITS + 2; c++) begin
      @(negedge clk);
      n_checks += 2;
      if (c <= NBITS || (c >= NBITS + 2 && c <= 2 * NBITS + 1)) begin
        if (b_strobe !== 1'b1) begin
          n_fail++; $display("FAIL b2b_strobe c=%0d got %b want 1", c, b_strobe);
        end
        if (b_bit !== (c <= NBITS ? e1[c - 1] : e2[c - NBITS - 2])) begin
          n_fail++;
          $display("FAIL b2b_bit c=%0d got %b want %b", c, b_bit, c <= NBITS ? e1[c - 1] : e2[c - NBITS - 2]);
        end
      end else begin
        if (b_strobe !== 1'b0) begin
          n_fail++; $display("FAIL b2b_strobe c=%0d got %b want 0", c, b_strobe);
        end
        if (b_done !== 1'b1 || b_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_done_ready c=%0d got %b%b want 11", c, b_done, b_ready);
        end
      end
      if (c == NBITS + 2) begin
        n_checks++;
        if (b_cw !== e2) begin
          n_fail++; $display("FAIL b2b_code_word got %h want %h", b_cw, e2);
        end
      end
      if (c == 1) b_data = 4'b1111;
      if (c == NBITS + 2) b_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (b_strobe !== 1'b0 || b_done !== 1'b0 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_after got strobe=%b done=%b ready=%b want 0 0 1", b_strobe, b_done, b_ready);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] rx;
    frame_g1(4'b0000, 4, rx);
    n_checks++;
    if (rx !== 8'h00) begin
      n_fail++; $display("FAIL ignore_bits got %h want 00", rx);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_strobe !== 1'b0 || a_cw !== 8'h00) begin
        n_fail++; $display("FAIL ignore_no_capture cyc=%0d got strobe=%b cw=%h want 0 00", i, a_strobe, a_cw);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rx;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 4'($urandom_range(0, 15));
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) a_valid = 1'b0;
    end
    n_checks++;
    if (a_strobe !== 1'b1) begin
      n_fail++; $display("FAIL abort_third_strobe got %b want 1", a_strobe);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_strobe !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_cw !== 8'h00 || a_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async got strobe=%b busy=%b ready=%b cw=%h bit=%b want 0 0 1 00 0",
               a_strobe, a_busy, a_ready, a_cw, a_bit);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      n_checks++;
      if (a_done !== 1'b0 || a_strobe !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_done cyc=%0d got done=%b strobe=%b want 0 0", i, a_done, a_strobe);
      end
    end
    frame_g1(4'b1011, 0, rx);
  endtask

  task automatic test_random_frames();
    logic [7:0] rx;
    logic [3:0] nib;
    for (int i = 0; i < 8; i++) begin
      nib = 4'($urandom_range(0, 15));
      frame_g1(nib, 0, rx);
      n_checks++;
      if (model_decode(rx) !== nib) begin
        n_fail++; $display("FAIL random_decode i=%0d got %h want %h", i, model_decode(rx), nib);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] rx;
    int flip;
    for (int n = 0; n < 16; n++) begin
      frame_g1(4'(n), 0, rx);
      flip = $urandom_range(0, NBITS);
      if (flip < NBITS) rx[flip] = ~rx[flip];
      n_checks++;
      if (model_decode(rx) !== 4'(n)) begin
        n_fail++; $display("FAIL loopback n=%0d flip=%0d got %h want %h", n, flip, model_decode(rx), 4'(n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_random_frames();
    test_loopback();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
